// File: rtl/vga_pkg.sv
// Shared timing constants, register map and pixel types for the VGA rectangle peripheral.
package vga_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int H_TOTAL2      = 1600;
  localparam int V_TOTAL       = 525;
  localparam int H_SYNC_START2 = 1312;
  localparam int H_SYNC_END2   = 1504;
  localparam int V_SYNC_START  = 490;
  localparam int V_SYNC_END    = 492;

  typedef enum logic [2:0] {
    REG_BG     = 3'd0,
    REG_RCOL   = 3'd1,
    REG_P0     = 3'd2,
    REG_P1     = 3'd3,
    REG_CTRL   = 3'd4,
    REG_STATUS = 3'd5
  } reg_addr_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One full set of programmable state; used for both the shadow and the live copy.
  typedef struct packed {
    rgb_t       bg;
    rgb_t       rcol;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
    logic       rect_en;
  } regs_t;

  // Half-open interval test; an empty interval (hi <= lo) never matches.
  function automatic logic in_span(input logic [9:0] val, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_counters.sv
// Raster counters plus sync/blank generation; two clk cycles per pixel.
module vga_counters
  import vga_pkg::*;
#(
  parameter int ACTIVE_CLKS  = 2 * H_ACTIVE,
  parameter int ACTIVE_LINES = V_ACTIVE,
  parameter int LINE_CLKS    = H_TOTAL2,
  parameter int FRAME_LINES  = V_TOTAL,
  parameter int HS_START     = H_SYNC_START2,
  parameter int HS_END       = H_SYNC_END2,
  parameter int VS_START     = V_SYNC_START,
  parameter int VS_END       = V_SYNC_END
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n
);

  localparam logic [10:0] H_LAST   = 11'(LINE_CLKS - 1);
  localparam logic [9:0]  V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [10:0] H_VIS    = 11'(ACTIVE_CLKS);
  localparam logic [9:0]  V_VIS    = 10'(ACTIVE_LINES);
  localparam logic [10:0] HS_FIRST = 11'(HS_START);
  localparam logic [10:0] HS_STOP  = 11'(HS_END);
  localparam logic [9:0]  VS_FIRST = 10'(VS_START);
  localparam logic [9:0]  VS_STOP  = 10'(VS_END);

  // Horizontal counter wraps each line and carries into the vertical counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign VGA_CLK     = hcount[0];
  assign VGA_HS      = !((hcount >= HS_FIRST) && (hcount < HS_STOP));
  assign VGA_VS      = !((vcount >= VS_FIRST) && (vcount < VS_STOP));
  assign VGA_BLANK_n = (hcount < H_VIS) && (vcount < V_VIS);

endmodule

// File: rtl/vga_rect_display.sv
// Avalon-MM VGA peripheral: solid background plus one rectangle, tear-free register commit.
module vga_rect_display
  import vga_pkg::*;
#(
  parameter int ACTIVE_CLKS  = 2 * H_ACTIVE,
  parameter int ACTIVE_LINES = V_ACTIVE,
  parameter int LINE_CLKS    = H_TOTAL2,
  parameter int FRAME_LINES  = V_TOTAL,
  parameter int HS_START     = H_SYNC_START2,
  parameter int HS_END       = H_SYNC_END2,
  parameter int VS_START     = V_SYNC_START,
  parameter int VS_END       = V_SYNC_END
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  localparam logic [9:0] V_VIS = 10'(ACTIVE_LINES);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        commit;
  logic        vblank;
  regs_t       shadow;
  regs_t       live;
  logic [15:0] frame_cnt;
  rgb_t        pixel;
  logic        unused_bits;

  vga_counters #(
    .ACTIVE_CLKS (ACTIVE_CLKS),
    .ACTIVE_LINES(ACTIVE_LINES),
    .LINE_CLKS   (LINE_CLKS),
    .FRAME_LINES (FRAME_LINES),
    .HS_START    (HS_START),
    .HS_END      (HS_END),
    .VS_START    (VS_START),
    .VS_END      (VS_END)
  ) u_counters (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .VGA_CLK    (VGA_CLK),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n)
  );

  assign px_x        = hcount[10:1];
  assign px_y        = vcount;
  assign commit      = (hcount == 11'd0) && (vcount == V_VIS);
  assign vblank      = (vcount >= V_VIS);
  assign VGA_SYNC_n  = 1'b0;
  assign unused_bits = &{1'b0, writedata[31:25]};

  // Bus writes only ever touch the shadow copy; bits outside each field are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (chipselect && write) begin
      case (reg_addr_e'(address))
        REG_BG:   shadow.bg <= writedata[23:0];
        REG_RCOL: shadow.rcol <= writedata[23:0];
        REG_P0: begin
          shadow.x0 <= writedata[9:0];
          shadow.y0 <= writedata[24:16];
        end
        REG_P1: begin
          shadow.x1 <= writedata[9:0];
          shadow.y1 <= writedata[24:16];
        end
        REG_CTRL: shadow.rect_en <= writedata[0];
        default:  ;
      endcase
    end
  end

  // Once per frame at the top of vblank the live set takes the pre-edge shadow value.
  always_ff @(posedge clk) begin
    if (reset) begin
      live      <= '0;
      frame_cnt <= '0;
    end else if (commit) begin
      live      <= shadow;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Registered read port; holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      case (reg_addr_e'(address))
        REG_BG:     readdata <= {8'd0, shadow.bg};
        REG_RCOL:   readdata <= {8'd0, shadow.rcol};
        REG_P0:     readdata <= {7'd0, shadow.y0, 6'd0, shadow.x0};
        REG_P1:     readdata <= {7'd0, shadow.y1, 6'd0, shadow.x1};
        REG_CTRL:   readdata <= {31'd0, shadow.rect_en};
        REG_STATUS: readdata <= {vblank, 15'd0, frame_cnt};
        default:    readdata <= '0;
      endcase
    end
  end

  // Pixel colour: black when blanked, rectangle colour inside the live rectangle, else background.
  always_comb begin
    pixel = '0;
    if (VGA_BLANK_n) begin
      pixel = live.bg;
      if (live.rect_en && in_span(px_x, live.x0, live.x1) &&
          in_span(px_y, {1'b0, live.y0}, {1'b0, live.y1})) begin
        pixel = live.rcol;
      end
    end
  end

  assign VGA_R = pixel.r;
  assign VGA_G = pixel.g;
  assign VGA_B = pixel.b;

endmodule

// File: tb/tb_vga_rect_display.sv
// Directed bench: a shrunken-raster instance for frame/commit behaviour, a full-size one for line timing.
module tb_vga_rect_display;

  localparam int ACT_CLKS  = 80;
  localparam int ACT_LINES = 48;
  localparam int LINE      = 112;
  localparam int LINES     = 55;
  localparam int HS0       = 88;
  localparam int HS1       = 100;
  localparam int VS0       = 50;
  localparam int VS1       = 52;
  localparam int FRAME     = LINE * LINES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  logic        idle_bit = 1'b0;
  logic [2:0]  idle_addr = '0;
  logic [31:0] idle_data = '0;
  logic [31:0] full_readdata;
  logic [7:0]  full_r, full_g, full_b;
  logic        full_clk, full_hs, full_vs, full_blank_n, full_sync_n;

  int check_count = 0;
  int error_count = 0;
  int cyc = 0;

  vga_rect_display #(
    .ACTIVE_CLKS (ACT_CLKS),
    .ACTIVE_LINES(ACT_LINES),
    .LINE_CLKS   (LINE),
    .FRAME_LINES (LINES),
    .HS_START    (HS0),
    .HS_END      (HS1),
    .VS_START    (VS0),
    .VS_END      (VS1)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  vga_rect_display dut_full (
    .clk(clk), .reset(reset), .chipselect(idle_bit), .write(idle_bit), .read(idle_bit),
    .address(idle_addr), .writedata(idle_data), .readdata(full_readdata),
    .VGA_R(full_r), .VGA_G(full_g), .VGA_B(full_b), .VGA_CLK(full_clk),
    .VGA_HS(full_hs), .VGA_VS(full_vs), .VGA_BLANK_n(full_blank_n), .VGA_SYNC_n(full_sync_n)
  );

  always #5 clk = ~clk;

  function automatic int hpos();
    return cyc % LINE;
  endfunction

  function automatic int vpos();
    return (cyc / LINE) % LINES;
  endfunction

  function automatic logic [31:0] pix();
    return {8'd0, vga_r, vga_g, vga_b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic [2:0] addr, input logic [31:0] data);
    chipselect = cs;
    write      = wr;
    read       = rd;
    address    = addr;
    writedata  = data;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] addr, input logic [31:0] expected, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, 32'd0);
    checkOutput(tag, readdata, expected);
  endtask

  task automatic goTo(input int h, input int v);
    while (!(hpos() == h && vpos() == v)) tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs_low, vs_low, blank_high, hs_falls, vs_first, lit, clk_err, hs_model, blank_model;
    int full_hs_low, full_hs_first, full_blank, full_vs_low, full_lit, full_clk_err;
    int green, wrong_bg, h, v;
    logic hs_prev;

    hs_low = 0; vs_low = 0; blank_high = 0; hs_falls = 0; vs_first = -1; lit = 0;
    clk_err = 0; hs_model = 0; blank_model = 0; hs_prev = 1'b1;
    full_hs_low = 0; full_hs_first = -1; full_blank = 0; full_vs_low = 0;
    full_lit = 0; full_clk_err = 0; green = 0; wrong_bg = 0;

    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    $display("[TB] reset released");

    checkOutput("rst_hs", 32'(vga_hs), 32'd1);
    checkOutput("rst_vs", 32'(vga_vs), 32'd1);
    checkOutput("rst_blank_n", 32'(vga_blank_n), 32'd1);
    checkOutput("rst_rgb", pix(), 32'd0);
    checkOutput("rst_vga_clk", 32'(vga_clk), 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("sync_n", 32'(vga_sync_n), 32'd0);
    checkOutput("full_rst_hs", 32'(full_hs), 32'd1);
    checkOutput("full_rst_vs", 32'(full_vs), 32'd1);
    checkOutput("full_rst_blank_n", 32'(full_blank_n), 32'd1);
    checkOutput("full_sync_n", 32'(full_sync_n), 32'd0);

    for (int i = 0; i < FRAME; i++) begin
      h = hpos();
      v = vpos();
      if (!vga_hs) hs_low++;
      if (!vga_vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if (vga_blank_n) blank_high++;
      if (hs_prev && !vga_hs) hs_falls++;
      hs_prev = vga_hs;
      if (pix() != 32'd0) lit++;
      if (vga_clk != 1'(h % 2)) clk_err++;
      if (vga_hs != !(h >= HS0 && h < HS1)) hs_model++;
      if (vga_blank_n != (h < ACT_CLKS && v < ACT_LINES)) blank_model++;
      if (i < 1600) begin
        if (!full_hs) begin
          full_hs_low++;
          if (full_hs_first < 0) full_hs_first = i;
        end
        if (full_blank_n) full_blank++;
        if (!full_vs) full_vs_low++;
        if ({full_r, full_g, full_b} != 24'd0) full_lit++;
        if (full_clk != 1'(i % 2)) full_clk_err++;
      end
      if (i == 1000) begin
        chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'h00FF0000;
      end else begin
        chipselect = 1'b0; write = 1'b0;
      end
      tick();
    end

    checkOutput("hs_low_cycles", 32'(hs_low), 32'(LINES * (HS1 - HS0)));
    checkOutput("hs_falls_per_frame", 32'(hs_falls), 32'(LINES));
    checkOutput("vs_low_cycles", 32'(vs_low), 32'(LINE * (VS1 - VS0)));
    checkOutput("vs_first_low", 32'(vs_first), 32'(VS0 * LINE));
    checkOutput("blank_high_cycles", 32'(blank_high), 32'(ACT_CLKS * ACT_LINES));
    checkOutput("hs_shape", 32'(hs_model), 32'd0);
    checkOutput("blank_shape", 32'(blank_model), 32'd0);
    checkOutput("vga_clk_phase", 32'(clk_err), 32'd0);
    checkOutput("frame1_black", 32'(lit), 32'd0);
    checkOutput("full_hs_low_width", 32'(full_hs_low), 32'd192);
    checkOutput("full_hs_first_low", 32'(full_hs_first), 32'd1312);
    checkOutput("full_blank_high", 32'(full_blank), 32'd1280);
    checkOutput("full_vs_line0", 32'(full_vs_low), 32'd0);
    checkOutput("full_line0_black", 32'(full_lit), 32'd0);
    checkOutput("full_vga_clk_phase", 32'(full_clk_err), 32'd0);

    checkOutput("frame2_first_pixel_red", pix(), 32'h00FF0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 32'h12345678);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'hAB00FF00);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'hFE14FC0A);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0028001E);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 32'hFFFFFFFF);
    readReg(3'd1, 32'h0000FF00, "rd_rcol");
    readReg(3'd2, 32'h0014000A, "rd_p0");
    readReg(3'd3, 32'h0028001E, "rd_p1");
    readReg(3'd4, 32'h00000001, "rd_ctrl");
    readReg(3'd6, 32'h00000000, "rd_addr6");
    readReg(3'd5, 32'h00000001, "rd_status_frame2");
    readReg(3'd0, 32'h00FF0000, "rd_bg");
    tick(); tick(); tick();
    checkOutput("readdata_hold", readdata, 32'h00FF0000);

    goTo(0, 0);
    goTo(20, 19);
    checkOutput("px_10_19_bg", pix(), 32'h00FF0000);
    goTo(18, 20);
    checkOutput("px_9_20_bg", pix(), 32'h00FF0000);
    goTo(20, 20);
    checkOutput("px_10_20_rect", pix(), 32'h0000FF00);
    goTo(58, 39);
    checkOutput("px_29_39_rect", pix(), 32'h0000FF00);
    goTo(60, 39);
    checkOutput("px_30_39_bg", pix(), 32'h00FF0000);
    goTo(58, 40);
    checkOutput("px_29_40_bg", pix(), 32'h00FF0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h00280005);
    goTo(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (vga_g != 8'd0) green++;
      if (vga_blank_n && pix() != 32'h00FF0000) wrong_bg++;
      tick();
    end
    checkOutput("empty_rect_no_green", 32'(green), 32'd0);
    checkOutput("empty_rect_bg_everywhere", 32'(wrong_bg), 32'd0);
    readReg(3'd5, 32'h00000004, "rd_status_frame5");

    goTo(0, ACT_LINES);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h000000FF);
    readReg(3'd5, 32'h80000005, "rd_status_after_commit");
    readReg(3'd0, 32'h000000FF, "rd_bg_blue");
    goTo(0, 0);
    checkOutput("race_frame_keeps_old_bg", pix(), 32'h00FF0000);
    tick();
    goTo(0, 0);
    checkOutput("race_next_frame_new_bg", pix(), 32'h000000FF);

    goTo(40, 30);
    readReg(3'd0, 32'h000000FF, "rd_before_reset");
    reset = 1'b1;
    tick();
    cyc = 0;
    checkOutput("midreset_hs", 32'(vga_hs), 32'd1);
    checkOutput("midreset_vs", 32'(vga_vs), 32'd1);
    checkOutput("midreset_blank_n", 32'(vga_blank_n), 32'd1);
    checkOutput("midreset_rgb", pix(), 32'd0);
    checkOutput("midreset_readdata", readdata, 32'd0);
    checkOutput("midreset_vga_clk", 32'(vga_clk), 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      readReg(3'(a), 32'd0, $sformatf("rd_after_reset_%0d", a));
    end
    goTo(HS0 - 1, 0);
    checkOutput("restart_hs_before", 32'(vga_hs), 32'd1);
    tick();
    checkOutput("restart_hs_at_start", 32'(vga_hs), 32'd0);
    checkOutput("full_readdata_idle", full_readdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
